uart_tx_arbiter: RTL

Shares the single uartTx serializer between NUM_REQ byte-stream requesters, such as the DTS row reporter, the header/status sender and a command echo. Grants are round-robin at packet granularity: a granted requester keeps the transmitter until its byte flagged last has been handed off. A per-packet stall watchdog revokes the grant from a requester that stops supplying bytes mid-packet. The block sits between the report/command logic and uartTx in the top level.

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one uartTx serializer between
// NUM_REQ byte-stream requesters, with a per-packet stall watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 1000000,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     timeout_cnt
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    state_t               state_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [IDX_W-1:0]     gidx_r;
    logic [IDX_W-1:0]     ptr_r;
    logic [STALL_W-1:0]   stall_r;
    logic                 last_r;
    logic                 tx_start_r;
    logic [7:0]           tx_data_r;
    logic [CNT_W-1:0]     tout_r;

    logic [IDX_W-1:0]     pick_s;
    logic                 pick_vld_s;
    logic [IDX_W-1:0]     next_ptr_s;
    logic [7:0]           lane_data_s;
    logic                 accept_s;
    int                   idx_s;

    // Round-robin pick: descending scan so the lowest offset from ptr wins.
    always_comb begin
        pick_s     = ptr_r;
        pick_vld_s = 1'b0;
        idx_s      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_s = int'(ptr_r) + k;
            if (idx_s >= NUM_REQ) begin
                idx_s = idx_s - NUM_REQ;
            end else begin
                idx_s = idx_s;
            end
            if (req_valid[idx_s]) begin
                pick_s     = IDX_W'(idx_s);
                pick_vld_s = 1'b1;
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Granted lane selection, accept qualification and pointer advance.
    always_comb begin
        lane_data_s = req_data[8*int'(gidx_r) +: 8];
        accept_s    = (state_r == SEND) && tx_ready && req_valid[gidx_r];
        if (gidx_r == IDX_W'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = gidx_r + IDX_W'(1);
        end
    end

    // Only the owner sees ready, and only while the serializer is idle in SEND.
    always_comb begin
        if ((state_r == SEND) && tx_ready) begin
            req_ready = grant_r;
        end else begin
            req_ready = '0;
        end
    end

    // Packet FSM with registered grant, tx handshake and watchdog.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            grant_r    <= '0;
            gidx_r     <= '0;
            ptr_r      <= '0;
            stall_r    <= '0;
            last_r     <= 1'b0;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
            tout_r     <= '0;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_vld_s) begin
                        grant_r <= NUM_REQ'(1) << pick_s;
                        gidx_r  <= pick_s;
                        stall_r <= '0;
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    if (accept_s) begin
                        tx_data_r  <= lane_data_s;
                        tx_start_r <= 1'b1;
                        last_r     <= req_last[gidx_r];
                        stall_r    <= '0;
                        state_r    <= WAIT_LOW;
                    end else if (!req_valid[gidx_r]) begin
                        // Stall time only accrues while the serializer could take a byte.
                        if (stall_r == STALL_W'(TIMEOUT - 1)) begin
                            grant_r <= '0;
                            ptr_r   <= next_ptr_s;
                            stall_r <= '0;
                            if (tout_r != {CNT_W{1'b1}}) begin
                                tout_r <= tout_r + CNT_W'(1);
                            end
                            state_r <= IDLE;
                        end else if (tx_ready) begin
                            stall_r <= stall_r + STALL_W'(1);
                        end
                    end
                end
                WAIT_LOW: begin
                    if (!tx_ready) begin
                        state_r <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (tx_ready) begin
                        if (last_r) begin
                            grant_r <= '0;
                            ptr_r   <= next_ptr_s;
                            state_r <= IDLE;
                        end else begin
                            state_r <= SEND;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign timeout_cnt = tout_r;
    assign busy        = (state_r != IDLE);

endmodule
